key_loader: RTL and testbench
=============================

Name: key_loader

Overview:
- Serial key-provisioning front end: the writer side of the `key` input consumed by the locked datapath logic.
- Accepts a bit-serial key frame over a valid/ready handshake and assembles it in a shadow register.
- Checks frame length and even parity, then commits the key atomically to a held output register.
- Sits between the test/provisioning port and every locked module's key input; downstream never sees a partially loaded key.

Parameters:
- KEY_W, 8: key width in bits; legal range 2..64.
- CNT_W, $clog2(KEY_W+2): bit-counter width (derived, not overridden).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- kin_valid  in  1  serial bit valid.
- kin_ready  out  1  loader can accept a bit.
- kin_bit  in  1  serial data bit, MSB of key first.
- kin_last  in  1  marks the final (parity) bit of a frame.
- key_out  out  KEY_W  committed key to locked logic.
- key_valid  out  1  key_out holds a committed key.
- key_err  out  1  one-cycle pulse on a rejected frame.
- busy  out  1  frame in progress (state != IDLE).

Behaviour:
Handshake:
- A bit is accepted on a rising clk edge when kin_valid && kin_ready.
- kin_ready = 1 in IDLE and SHIFT; 0 in CHECK and ERR.
- kin_valid may stay high through ready-low cycles; the bit is held, not dropped.

Frame format:
- KEY_W key bits, MSB first, followed by 1 even-parity bit carrying kin_last=1.
- Parity rule: XOR of all KEY_W+1 bits must be 0.

Datapath:
- Shadow register: shadow <= {shadow[KEY_W-2:0], kin_bit} on each accepted key bit.
- The parity bit is not shifted into shadow; it goes to par_r.
- cnt counts accepted bits; it clears on entry to IDLE.

FSM, 4 states:
- IDLE: on an accepted bit, enter SHIFT with cnt=1.
  - If that bit has kin_last=1, go to ERR instead (frame too short).
- SHIFT, on each accepted bit:
  - kin_last=1 and cnt==KEY_W: latch par_r and go to CHECK.
  - kin_last=1 and cnt<KEY_W: go to ERR (short frame).
  - kin_last=0 and cnt==KEY_W: go to ERR (long frame).
  - Otherwise stay in SHIFT and increment cnt.
- CHECK (1 cycle):
  - ^shadow ^ par_r == 0: key_out <= shadow, key_valid <= 1, go to IDLE.
  - Otherwise go to ERR.
- ERR (1 cycle): key_err=1, then go to IDLE. key_out and key_valid keep their previous values.

Latency:
- Parity bit accepted at edge N; key_out/key_valid update at edge N+1.
- Next frame's first bit is accepted no earlier than edge N+2.

Reset (rst low, asynchronous):
- key_out=0, key_valid=0, key_err=0, busy=0, shadow=0, cnt=0, state=IDLE.
- Reset mid-frame discards the partial frame. kin_ready returns to 1 on the first edge after release.

Other rules:
- key_valid, once set, stays 1 until reset, or until zeroize when the optional feature is compiled in.
- A reload holds the old key_out until the new commit; there is no glitch.
- No timeout: an idle gap within a frame holds state indefinitely.

Optional Feature:
- Macro: KEY_LOADER_ZEROIZE_EN.
- Defined: entering ERR also clears key_out to 0 and key_valid to 0 in the same edge as key_err asserts. Failed provisioning therefore leaves the design locked.
- Undefined: ERR leaves key_out and key_valid untouched.

Decomposition:
- Package key_loader_pkg holds:
  - state enum klr_state_e {KLR_IDLE, KLR_SHIFT, KLR_CHECK, KLR_ERR};
  - localparam KLR_PAR_EVEN=1'b0;
  - default KEY_W.
- Sub-module key_parity: a parameterised XOR-reduce over KEY_W+1 bits, output par_ok. It is shared with future key-readback checkers.

Test Plan:
1. Hold rst=0 for 3 cycles, then release -> key_out=0x00, key_valid=0, key_err=0, busy=0; kin_ready=1 after the first edge.
2. Send bits of 0xA5 MSB-first, then parity 0 with kin_last -> key_out=0xA5 and key_valid=1 one edge after the parity bit; kin_ready=0 for exactly 1 cycle (CHECK).
3. After test 2, send 0x3C with parity 1 -> key_err pulses 1 cycle, key_out stays 0xA5. With KEY_LOADER_ZEROIZE_EN: key_out=0x00, key_valid=0.
4. Assert kin_last on the 5th bit -> ERR (short). Separately, send 9 bits without kin_last -> ERR on the 9th bit. key_out unchanged in both cases.
5. Keep kin_valid high continuously across two back-to-back frames 0x0F/p0 then 0xF0/p0 -> both commit; key_out=0xF0 at the end; the CHECK ready-low cycle loses no bit.
6. Assert rst after 4 bits of a frame -> state IDLE and key_out=0 immediately. A full 0x81/p0 frame after release commits 0x81.

Source files
------------

// File: rtl/key_loader_pkg.sv
// Shared types and constants for the serial key loader and its parity checker.
package key_loader_pkg;
  typedef enum logic [1:0] {KLR_IDLE, KLR_SHIFT, KLR_CHECK, KLR_ERR} klr_state_e;
  localparam logic KLR_PAR_EVEN = 1'b0;
  localparam int   KLR_KEY_W    = 8;
endpackage

// File: rtl/key_parity.sv
// Even-parity checker over a key plus its parity bit; also used by key readback checkers.
module key_parity
  import key_loader_pkg::*;
#(
  parameter int W = KLR_KEY_W + 1
) (
  input  logic [W-1:0] i_data,
  output logic         o_par_ok
);
  assign o_par_ok = ((^i_data) == KLR_PAR_EVEN);
endmodule

// File: rtl/key_loader.sv
// Bit-serial key loader: shifts a framed key into a shadow register, checks length and
// even parity, then commits atomically. Optional KEY_LOADER_ZEROIZE_EN clears the key on error.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_W = KLR_KEY_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             kin_valid,
  output logic             kin_ready,
  input  logic             kin_bit,
  input  logic             kin_last,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err,
  output logic             busy
);
  localparam int CNT_W = $clog2(KEY_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);

  klr_state_e       r_state, w_nstate;
  logic [CNT_W-1:0] r_cnt;
  logic [KEY_W-1:0] r_shadow;
  logic             r_par;
  logic             w_acc;
  logic             w_par_ok;
  logic             w_shift;

  assign kin_ready = (r_state == KLR_IDLE) || (r_state == KLR_SHIFT);
  assign w_acc     = kin_valid && kin_ready;
  assign key_err   = (r_state == KLR_ERR);
  assign busy      = (r_state != KLR_IDLE);
  // Only genuine key bits enter the shadow; a long frame's excess bit is dropped.
  assign w_shift   = w_acc && !kin_last && (r_cnt != CNT_FULL);

  key_parity #(.W(KEY_W + 1)) u_par (
    .i_data   ({r_shadow, r_par}),
    .o_par_ok (w_par_ok)
  );

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      KLR_IDLE:
        if (w_acc) w_nstate = kin_last ? KLR_ERR : KLR_SHIFT;
      KLR_SHIFT:
        if (w_acc) begin
          if (kin_last)               w_nstate = (r_cnt == CNT_FULL) ? KLR_CHECK : KLR_ERR;
          else if (r_cnt == CNT_FULL) w_nstate = KLR_ERR;
        end
      KLR_CHECK: w_nstate = w_par_ok ? KLR_IDLE : KLR_ERR;
      KLR_ERR:   w_nstate = KLR_IDLE;
      default:   w_nstate = KLR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= KLR_IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_par    <= 1'b0;
    end else begin
      r_state <= w_nstate;
      if (w_nstate == KLR_IDLE)                r_cnt <= '0;
      else if (w_acc && r_state == KLR_IDLE)   r_cnt <= CNT_W'(1);
      else if (w_acc && w_nstate == KLR_SHIFT) r_cnt <= r_cnt + CNT_W'(1);
      if (w_shift) r_shadow <= {r_shadow[KEY_W-2:0], kin_bit};
      if (w_acc && kin_last) r_par <= kin_bit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_out   <= '0;
      key_valid <= 1'b0;
    end else if (r_state == KLR_CHECK && w_par_ok) begin
      key_out   <= r_shadow;
      key_valid <= 1'b1;
    end
`ifdef KEY_LOADER_ZEROIZE_EN
    else if (w_nstate == KLR_ERR) begin
      key_out   <= '0;
      key_valid <= 1'b0;
    end
`endif
  end
endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed scenarios plus randomized frames against a
// frame-level model (commit/reject decided from frame length, kin_last position and parity).
module tb_key_loader;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          kin_valid = 1'b0, kin_bit = 1'b0, kin_last = 1'b0;
  logic          kin_ready, key_valid, key_err, busy;
  logic [KW-1:0] key_out;

  logic [KW-1:0] exp_key   = '0;
  logic          exp_valid = 1'b0;
  int            n_tests = 0, n_fail = 0;

  key_loader #(.KEY_W(KW)) dut (
    .clk(clk), .rst(rst), .kin_valid(kin_valid), .kin_ready(kin_ready),
    .kin_bit(kin_bit), .kin_last(kin_last), .key_out(key_out),
    .key_valid(key_valid), .key_err(key_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Presents one bit at a negedge and returns on the negedge after it is accepted.
  task automatic send_bit(input logic b, input logic l, output int waits);
    kin_valid = 1'b1; kin_bit = b; kin_last = l; waits = 0;
    while (!kin_ready && waits < 20) begin @(negedge clk); waits++; end
    n_tests++;
    if (waits >= 20) begin n_fail++; $display("FAIL handshake_timeout ready stuck low after %0d cycles", waits); end
    @(negedge clk);
  endtask

  // Sends n bits (MSB of bits[n-1:0] first), kin_last on index last_idx (-1 = none),
  // then checks commit or rejection against the frame-level model.
  task automatic run_frame(input logic [31:0] bits, input int n, input int last_idx,
                           input bit hold, input logic hold_bit, input int gap_pct);
    int w, kind;
    if (n == KW + 1 && last_idx == KW) kind = (^bits[KW:0]) ? 1 : 0;
    else kind = 2;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < gap_pct) begin
        kin_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      send_bit(bits[n-1-i], (i == last_idx), w);
    end
    if (hold) begin kin_bit = hold_bit; kin_last = 1'b0; end
    else kin_valid = 1'b0;
    if (kind == 0) begin
      n_tests++;
      if (kin_ready !== 1'b0 || busy !== 1'b1 || key_out !== exp_key) begin
        n_fail++; $display("FAIL check_cycle ready=%b busy=%b key=%h want ready=0 busy=1 key=%h", kin_ready, busy, key_out, exp_key);
      end
      @(negedge clk);
      exp_key = bits[KW:1]; exp_valid = 1'b1;
      n_tests++;
      if (key_out !== exp_key || key_valid !== 1'b1 || key_err !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL commit key=%h valid=%b err=%b busy=%b want key=%h valid=1 err=0 busy=0", key_out, key_valid, key_err, busy, exp_key);
      end
    end else begin
      if (kind == 1) begin
        n_tests++;
        if (busy !== 1'b1 || kin_ready !== 1'b0) begin
          n_fail++; $display("FAIL parity_check_cycle busy=%b ready=%b want busy=1 ready=0", busy, kin_ready);
        end
        @(negedge clk);
      end
`ifdef KEY_LOADER_ZEROIZE_EN
      exp_key = '0; exp_valid = 1'b0;
`endif
      n_tests++;
      if (key_err !== 1'b1 || key_out !== exp_key || key_valid !== exp_valid || kin_ready !== 1'b0) begin
        n_fail++; $display("FAIL reject kind=%0d err=%b key=%h valid=%b ready=%b want err=1 key=%h valid=%b ready=0", kind, key_err, key_out, key_valid, kin_ready, exp_key, exp_valid);
      end
      @(negedge clk);
      n_tests++;
      if (key_err !== 1'b0 || busy !== 1'b0 || key_out !== exp_key) begin
        n_fail++; $display("FAIL err_pulse_end err=%b busy=%b key=%h want err=0 busy=0 key=%h", key_err, busy, key_out, exp_key);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (key_out !== '0 || key_valid !== 1'b0 || key_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs key=%h valid=%b err=%b busy=%b want all 0", key_out, key_valid, key_err, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (kin_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release ready=%b busy=%b want ready=1 busy=0", kin_ready, busy);
    end
  endtask

  task automatic test_commit();
    run_frame({23'd0, 8'hA5, 1'b0}, KW + 1, KW, 1'b0, 1'b0, 0);
  endtask

  task automatic test_bad_parity();
    run_frame({23'd0, 8'h3C, 1'b1}, KW + 1, KW, 1'b0, 1'b0, 0);
  endtask

  task automatic test_framing();
    logic [31:0] r;
    r = $urandom;
    run_frame(r, 5, 4, 1'b0, 1'b0, 0);
    r = $urandom;
    run_frame(r, KW + 1, -1, 1'b0, 1'b0, 0);
    run_frame(r, 1, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    run_frame({23'd0, 8'h0F, 1'b0}, KW + 1, KW, 1'b1, 1'b1, 0);
    n_tests++;
    if (kin_valid !== 1'b1 || key_out !== 8'h0F) begin
      n_fail++; $display("FAIL b2b_first key=%h valid_in=%b want key=0f valid_in=1", key_out, kin_valid);
    end
    run_frame({23'd0, 8'hF0, 1'b0}, KW + 1, KW, 1'b0, 1'b0, 0);
    n_tests++;
    if (key_out !== 8'hF0) begin
      n_fail++; $display("FAIL b2b_final key=%h want f0", key_out);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0, w);
    #2 rst = 1'b0;
    #1;
    exp_key = '0; exp_valid = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || key_out !== '0 || key_valid !== 1'b0 || kin_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid busy=%b key=%h valid=%b ready=%b want busy=0 key=00 valid=0 ready=1", busy, key_out, key_valid, kin_ready);
    end
    kin_valid = 1'b0; kin_last = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_frame({23'd0, 8'h81, 1'b0}, KW + 1, KW, 1'b0, 1'b0, 0);
  endtask

  task automatic test_random();
    logic [KW-1:0] k;
    logic [31:0]   r;
    int            kind, len;
    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 3);
      k = KW'($urandom);
      r = $urandom;
      case (kind)
        0: run_frame({23'd0, k, ^k},  KW + 1, KW, 1'b0, 1'b0, 30);
        1: run_frame({23'd0, k, ~^k}, KW + 1, KW, 1'b0, 1'b0, 30);
        2: begin len = $urandom_range(1, KW); run_frame(r, len, len - 1, 1'b0, 1'b0, 30); end
        default: run_frame(r, KW + 1, -1, 1'b0, 1'b0, 30);
      endcase
      if ($urandom_range(1)) @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_commit();
    test_bad_parity();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
